change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vending_pkg.sv | 56 +++++
 rtl/ack_timer.sv | 43 ++++
 rtl/change_dispenser.sv | 235 +++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared types and helpers for the change dispenser.
//   state_e    : dispenser FSM states
//   NICKEL_VAL : value of a nickel in cents
//   DIME_VAL   : value of a dime in cents
//   helpers    : multiple-of-5 test, coin value lookup, saturating arithmetic
// ---------------------------------------------------------------------------
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EJECT  = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } state_e;

  localparam logic [3:0] NICKEL_VAL = 4'd5;
  localparam logic [3:0] DIME_VAL   = 4'd10;

  // Only these 4-bit amounts can be paid exactly with dimes and nickels.
  function automatic logic is_mult5(input logic [3:0] v);
    case (v)
      4'd0, 4'd5, 4'd10, 4'd15: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] coin_value(input logic is_dime);
    if (is_dime) begin
      return DIME_VAL;
    end else begin
      return NICKEL_VAL;
    end
  endfunction

  // Hopper counts must never wrap below zero.
  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    if (v == 4'd0) begin
      return 4'd0;
    end else begin
      return v - 4'd1;
    end
  endfunction

  // Remaining amount must never wrap below zero.
  function automatic logic [3:0] sat_sub(input logic [3:0] v, input logic [3:0] c);
    if (v >= c) begin
      return v - c;
    end else begin
      return 4'd0;
    end
  endfunction

endpackage

// File: rtl/ack_timer.sv
// ---------------------------------------------------------------------------
// ack_timer
// Down-counter that bounds how long a coin request may wait for coin_ack.
//   i_clk      : clock, rising edge
//   i_reset_n  : synchronous active-low reset (counter -> 0)
//   i_clear    : reload the counter to CYCLES-1 (issued on EJECT entry)
//   i_en       : count down while waiting for the acknowledge
//   o_expired  : counter has reached zero; with i_en held since the clear,
//                this is true during the CYCLES-th waiting cycle
// ---------------------------------------------------------------------------
module ack_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  // Loading CYCLES-1 makes the count reach zero in the final waiting cycle,
  // so the owner can let an ack in that same cycle take priority.
  localparam logic [W-1:0] L_LOAD = W'(CYCLES - 1);

  logic [W-1:0] r_cnt;

  // Counter register: reload on clear, otherwise count down to zero and hold.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= L_LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Pays out an owed amount (0..15 cents) using dimes first, then nickels,
// one coin at a time with a handshake to the ejection mechanism.
//   clk          : clock, rising edge
//   reset_n      : synchronous active-low reset
//   load         : strobe, capture change_in (honoured in IDLE only)
//   change_in    : amount owed in cents
//   refill       : strobe, reload both hoppers (honoured in IDLE/FAULT only)
//   clr_fault    : strobe, leave FAULT back to IDLE
//   coin_ack     : mechanism finished ejecting the requested coin
//   dime_req     : request one dime (held until ack or timeout)
//   nickel_req   : request one nickel (held until ack or timeout)
//   busy         : transaction in progress or faulted
//   done         : one-cycle pulse when the amount has been fully paid
//   fault        : level, dispenser is in FAULT
//   dime_cnt     : dimes left in hopper
//   nickel_cnt   : nickels left in hopper
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned DIME_INIT      = 4,
  parameter int unsigned NICKEL_INIT    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] change_in,
  input  logic       refill,
  input  logic       clr_fault,
  input  logic       coin_ack,
  output logic       dime_req,
  output logic       nickel_req,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] dime_cnt,
  output logic [3:0] nickel_cnt
);

  localparam logic [3:0] L_DIME_INIT   = 4'(DIME_INIT);
  localparam logic [3:0] L_NICKEL_INIT = 4'(NICKEL_INIT);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_remaining;
  logic [3:0] w_remaining_nxt;
  logic       r_coin_dime;      // coin being requested in EJECT: 1 dime, 0 nickel
  logic       w_coin_dime_nxt;
  logic [3:0] r_dime_cnt;
  logic [3:0] w_dime_cnt_nxt;
  logic [3:0] r_nickel_cnt;
  logic [3:0] w_nickel_cnt_nxt;

  logic       r_dime_req;
  logic       r_nickel_req;
  logic       r_busy;
  logic       r_done;
  logic       r_fault;
  logic       w_dime_req_nxt;
  logic       w_nickel_req_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_fault_nxt;

  logic       w_timer_clear;
  logic       w_timer_en;
  logic       w_timer_expired;

  ack_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_ack_timer (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_clear   (w_timer_clear),
    .i_en      (w_timer_en),
    .o_expired (w_timer_expired)
  );

  // The timer only runs while a coin request is outstanding.
  assign w_timer_en = (r_state == EJECT);

  // State register together with the datapath registers it governs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_remaining  <= 4'd0;
      r_coin_dime  <= 1'b0;
      r_dime_cnt   <= L_DIME_INIT;
      r_nickel_cnt <= L_NICKEL_INIT;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_coin_dime  <= w_coin_dime_nxt;
      r_dime_cnt   <= w_dime_cnt_nxt;
      r_nickel_cnt <= w_nickel_cnt_nxt;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_remaining_nxt  = r_remaining;
    w_coin_dime_nxt  = r_coin_dime;
    w_dime_cnt_nxt   = r_dime_cnt;
    w_nickel_cnt_nxt = r_nickel_cnt;
    w_timer_clear    = 1'b0;

    case (r_state)
      IDLE: begin
        // Refill lands in the same edge as a load, so the first SELECT
        // already sees full hoppers.
        if (refill) begin
          w_dime_cnt_nxt   = L_DIME_INIT;
          w_nickel_cnt_nxt = L_NICKEL_INIT;
        end else begin
          w_dime_cnt_nxt   = r_dime_cnt;
          w_nickel_cnt_nxt = r_nickel_cnt;
        end
        if (load) begin
          w_remaining_nxt = change_in;
          if (change_in == 4'd0) begin
            w_state_nxt = DONE;
          end else if (!is_mult5(change_in)) begin
            w_state_nxt = FAULT;
          end else begin
            w_state_nxt = SELECT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end

      SELECT: begin
        if ((r_remaining >= DIME_VAL) && (r_dime_cnt != 4'd0)) begin
          w_state_nxt     = EJECT;
          w_coin_dime_nxt = 1'b1;
          w_timer_clear   = 1'b1;
        end else if ((r_remaining >= NICKEL_VAL) && (r_nickel_cnt != 4'd0)) begin
          w_state_nxt     = EJECT;
          w_coin_dime_nxt = 1'b0;
          w_timer_clear   = 1'b1;
        end else if (r_remaining == 4'd0) begin
          w_state_nxt = DONE;
        end else begin
          // Owed amount cannot be paid from what is left in the hoppers.
          w_state_nxt = FAULT;
        end
      end

      EJECT: begin
        // An ack in the final waiting cycle beats the timeout.
        if (coin_ack) begin
          w_state_nxt     = SELECT;
          w_remaining_nxt = sat_sub(r_remaining, coin_value(r_coin_dime));
          if (r_coin_dime) begin
            w_dime_cnt_nxt = sat_dec(r_dime_cnt);
          end else begin
            w_nickel_cnt_nxt = sat_dec(r_nickel_cnt);
          end
        end else if (w_timer_expired) begin
          w_state_nxt = FAULT;
        end else begin
          w_state_nxt = EJECT;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      FAULT: begin
        if (refill) begin
          w_dime_cnt_nxt   = L_DIME_INIT;
          w_nickel_cnt_nxt = L_NICKEL_INIT;
        end else begin
          w_dime_cnt_nxt   = r_dime_cnt;
          w_nickel_cnt_nxt = r_nickel_cnt;
        end
        if (clr_fault) begin
          w_state_nxt     = IDLE;
          w_remaining_nxt = 4'd0;
        end else begin
          w_state_nxt = FAULT;
        end
      end

      default: begin
        // Corrupted state encoding: park safely with no coin requested.
        w_state_nxt     = FAULT;
        w_remaining_nxt = 4'd0;
        w_coin_dime_nxt = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    w_busy_nxt       = (w_state_nxt != IDLE);
    w_done_nxt       = (w_state_nxt == DONE);
    w_fault_nxt      = (w_state_nxt == FAULT);
    w_dime_req_nxt   = (w_state_nxt == EJECT) && w_coin_dime_nxt;
    w_nickel_req_nxt = (w_state_nxt == EJECT) && !w_coin_dime_nxt;
  end

  // Output registers; reset drops any outstanding request on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dime_req   <= 1'b0;
      r_nickel_req <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_dime_req   <= w_dime_req_nxt;
      r_nickel_req <= w_nickel_req_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  assign dime_req   = r_dime_req;
  assign nickel_req = r_nickel_req;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fault      = r_fault;
  assign dime_cnt   = r_dime_cnt;
  assign nickel_cnt = r_nickel_cnt;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. Coin requests, done pulses and fault
// entries seen on the default-parameter instance are matched in order
// against an expected-event queue filled as each stimulus is applied.
module tb_change_dispenser;

  localparam int EV_DIME   = 1;
  localparam int EV_NICKEL = 2;
  localparam int EV_DONE   = 3;
  localparam int EV_FAULT  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic       load_b;
  logic [3:0] change_in;
  logic       refill;
  logic       clr_fault;
  logic       coin_ack;

  logic       dime_req, nickel_req, busy, done, fault;
  logic [3:0] dime_cnt, nickel_cnt;
  logic       b_dime_req, b_nickel_req, b_busy, b_done, b_fault;
  logic [3:0] b_dime_cnt, b_nickel_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int sb_q[$];

  logic prev_dime = 1'b0;
  logic prev_nickel = 1'b0;
  logic prev_fault = 1'b0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .change_in  (change_in),
    .refill     (refill),
    .clr_fault  (clr_fault),
    .coin_ack   (coin_ack),
    .dime_req   (dime_req),
    .nickel_req (nickel_req),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .dime_cnt   (dime_cnt),
    .nickel_cnt (nickel_cnt)
  );

  change_dispenser #(.DIME_INIT(0)) dut_nodime (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_b),
    .change_in  (change_in),
    .refill     (refill),
    .clr_fault  (clr_fault),
    .coin_ack   (coin_ack),
    .dime_req   (b_dime_req),
    .nickel_req (b_nickel_req),
    .busy       (b_busy),
    .done       (b_done),
    .fault      (b_fault),
    .dime_cnt   (b_dime_cnt),
    .nickel_cnt (b_nickel_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_event(input int ev);
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_errors++;
      $error("FAIL sb_unexpected: observed event %0d expected no event", ev);
    end
    if (sb_q.size() != 0) begin
      check("sb_order", ev, sb_q.pop_front());
    end
  endtask

  // Output monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (dime_req && !prev_dime)     sb_event(EV_DIME);
    if (nickel_req && !prev_nickel) sb_event(EV_NICKEL);
    if (done)                       sb_event(EV_DONE);
    if (fault && !prev_fault)       sb_event(EV_FAULT);
    prev_dime   <= dime_req;
    prev_nickel <= nickel_req;
    prev_fault  <= fault;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (dime_req || nickel_req) break;
      tick();
    end
    check(tag, dime_req | nickel_req, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      tick();
    end
    check(tag, done, 1'b1);
  endtask

  // Wait for a request, check its kind, ack after 'delay' cycles.
  task automatic serve(input string tag, input logic exp_dime, input int delay);
    wait_req({tag, "_req"});
    check({tag, "_kind"}, {dime_req, nickel_req}, {exp_dime, !exp_dime});
    repeat (delay) tick();
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    check({tag, "_drop"}, {dime_req, nickel_req}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_nick;
    int n_dime;
    int n_high;
    logic got_done;

    reset_n = 1'b0; load = 1'b0; load_b = 1'b0; change_in = 4'd0;
    refill = 1'b0; clr_fault = 1'b0; coin_ack = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    check("reset_outputs", {busy, done, fault, dime_req, nickel_req, dime_cnt, nickel_cnt},
          {5'b00000, 4'd4, 4'd4});
    check("reset_nodime_cnt", {b_dime_cnt, b_nickel_cnt}, {4'd0, 4'd4});

    // 5 cents: one nickel, ack three cycles after the request.
    load = 1'b1; change_in = 4'd5;
    sb_q.push_back(EV_NICKEL); sb_q.push_back(EV_DONE);
    tick();
    load = 1'b0;
    check("t5_busy_after_load", {busy, nickel_req, dime_req}, 3'b100);
    tick();
    check("t5_first_req_latency", {dime_req, nickel_req}, 2'b01);
    repeat (3) tick();
    check("t5_req_held", nickel_req, 1'b1);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    check("t5_req_drop_cnt", {nickel_req, nickel_cnt, dime_cnt}, {1'b0, 4'd3, 4'd4});
    wait_done("t5_done");
    tick();
    check("t5_idle", {done, busy}, 2'b00);

    // 15 cents: dime then nickel; refill during the transaction is ignored.
    refill = 1'b1;
    tick();
    refill = 1'b0;
    check("refill_idle", {dime_cnt, nickel_cnt}, {4'd4, 4'd4});
    load = 1'b1; change_in = 4'd15;
    sb_q.push_back(EV_DIME); sb_q.push_back(EV_NICKEL); sb_q.push_back(EV_DONE);
    tick();
    load = 1'b0;
    serve("t15_dime", 1'b1, 1);
    refill = 1'b1;
    tick();
    refill = 1'b0;
    serve("t15_nickel", 1'b0, 0);
    wait_done("t15_done");
    tick();
    check("t15_counts", {dime_cnt, nickel_cnt, busy, done}, {4'd3, 4'd3, 2'b00});

    // No-dime instance, 10 cents: two nickels. Acks also reach the idle dut.
    load_b = 1'b1; change_in = 4'd10;
    tick();
    load_b = 1'b0;
    n_nick = 0; n_dime = 0; got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (b_done) begin
        got_done = 1'b1;
      end else if (b_nickel_req || b_dime_req) begin
        if (b_nickel_req) n_nick++;
        else n_dime++;
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
      end else begin
        tick();
      end
    end
    check("nd_done", got_done, 1'b1);
    check("nd_coin_counts", {n_nick[7:0], n_dime[7:0]}, {8'd2, 8'd0});
    check("nd_hoppers", {b_dime_cnt, b_nickel_cnt}, {4'd0, 4'd2});
    check("ack_ignored_idle", {dime_cnt, nickel_cnt, busy}, {4'd3, 4'd3, 1'b0});

    // 7 cents: not payable, fault at once; load ignored while faulted.
    load = 1'b1; change_in = 4'd7;
    sb_q.push_back(EV_FAULT);
    tick();
    load = 1'b0;
    check("t7_fault", {fault, busy, dime_req, nickel_req}, 4'b1100);
    load = 1'b1; change_in = 4'd5;
    tick();
    load = 1'b0;
    tick();
    check("t7_fault_held", {fault, busy, dime_req, nickel_req}, 4'b1100);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("t7_clr", {fault, busy}, 2'b00);

    // 0 cents: straight to a single done pulse.
    load = 1'b1; change_in = 4'd0;
    sb_q.push_back(EV_DONE);
    tick();
    load = 1'b0;
    check("t0_done", {done, busy}, 2'b11);
    tick();
    check("t0_idle", {done, busy}, 2'b00);

    // 10 cents with no ack: dime request for 16 cycles, then fault.
    load = 1'b1; change_in = 4'd10;
    sb_q.push_back(EV_DIME); sb_q.push_back(EV_FAULT);
    tick();
    load = 1'b0;
    wait_req("to_req");
    n_high = 0;
    while (dime_req && n_high < 40) begin
      n_high++;
      tick();
    end
    check("to_req_cycles", n_high, 16);
    check("to_fault", {fault, dime_req, nickel_req, dime_cnt}, {3'b100, 4'd3});
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("to_clr", fault, 1'b0);

    // 10 cents, ack in the 16th waiting cycle wins over the timeout.
    load = 1'b1; change_in = 4'd10;
    sb_q.push_back(EV_DIME); sb_q.push_back(EV_DONE);
    tick();
    load = 1'b0;
    tick();
    repeat (15) tick();
    check("ack16_still_waiting", {dime_req, fault}, 2'b10);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    check("ack16_no_fault", {fault, dime_req, dime_cnt}, {2'b00, 4'd2});
    wait_done("ack16_done");
    tick();

    // Refill together with load: refill first, then reset mid-EJECT.
    refill = 1'b1; load = 1'b1; change_in = 4'd15;
    sb_q.push_back(EV_DIME);
    tick();
    refill = 1'b0; load = 1'b0;
    check("refill_with_load", {dime_cnt, nickel_cnt, busy}, {4'd4, 4'd4, 1'b1});
    tick();
    check("rst_pre_req", dime_req, 1'b1);
    reset_n = 1'b0;
    tick();
    check("rst_mid_eject", {dime_req, nickel_req, busy, done, fault, dime_cnt, nickel_cnt},
          {5'b00000, 4'd4, 4'd4});
    reset_n = 1'b1;
    tick();
    check("rst_no_done", {done, busy}, 2'b00);
    repeat (3) tick();
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
